// File: rtl/rightmost_bit_sequencer_pkg.sv
// Shared types and constants for the rightmost-bit sequencer.
// Holds the state encoding, the index-width helper and the width-correct ONE constant.
package rightmost_bit_sequencer_pkg;

    typedef enum logic {
        STATE_IDLE = 1'b0,
        STATE_RUN  = 1'b1
    } state_e;

    // Resized to the mask width at the point of use so r - 1 and ~r + 1 stay WORD_WIDTH wide.
    localparam int unsigned ONE = 1;

    // Index width for a one-hot of n bits. Never returns less than 1.
    function automatic int unsigned index_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/rightmost_bit_sequencer_onehot_to_binary.sv
// One-hot to binary encoder used for the optional bit_index output.
// An all-zero input encodes to zero.
module onehot_to_binary
    import rightmost_bit_sequencer_pkg::*;
#(
    parameter int unsigned WORD_WIDTH  = 8,
    parameter int unsigned INDEX_WIDTH = index_width(WORD_WIDTH)
) (
    input  logic [WORD_WIDTH-1:0]  onehot_i,
    output logic [INDEX_WIDTH-1:0] index_o
);

    always_comb begin
        index_o = '0;
        for (int unsigned i = 0; i < WORD_WIDTH; i++) begin
            if (onehot_i[i]) begin
                index_o = index_o | INDEX_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/rightmost_bit_sequencer.sv
// Emits the set bits of a request mask one per handshake, lowest bit first.
// Optional bit_index output enabled by defining RIGHTMOST_BIT_SEQUENCER_INDEX_EN.
module rightmost_bit_sequencer
    import rightmost_bit_sequencer_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 8
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic                                 mask_valid,
    output logic                                 mask_ready,
    input  logic [WORD_WIDTH-1:0]                mask_in,
    output logic                                 bit_valid,
    input  logic                                 bit_ready,
    output logic [WORD_WIDTH-1:0]                bit_onehot,
`ifdef RIGHTMOST_BIT_SEQUENCER_INDEX_EN
    output logic [index_width(WORD_WIDTH)-1:0]   bit_index,
`endif
    output logic                                 bit_last
);

    localparam logic [WORD_WIDTH-1:0] ONE_W = WORD_WIDTH'(ONE);

    state_e                state_q, state_d;
    logic [WORD_WIDTH-1:0] rem_q, rem_d;
    logic                  run;
    logic                  last;
    logic                  mask_nz;
    logic [WORD_WIDTH-1:0] lsb;
    logic [WORD_WIDTH-1:0] cleared;

    assign run     = (state_q == STATE_RUN);
    assign mask_nz = (mask_in != '0);
    assign lsb     = rem_q & (~rem_q + ONE_W);
    assign cleared = rem_q & (rem_q - ONE_W);
    assign last    = run && (cleared == '0);

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        mask_ready = 1'b0;
        unique case (state_q)
            STATE_IDLE: begin
                mask_ready = 1'b1;
                if (mask_valid && mask_nz) begin
                    rem_d   = mask_in;
                    state_d = STATE_RUN;
                end
            end
            STATE_RUN: begin
                if (bit_ready) begin
                    rem_d = cleared;
                    // Last beat overlaps the next load so back-to-back masks have no bubble.
                    if (last) begin
                        mask_ready = 1'b1;
                        if (mask_valid && mask_nz) begin
                            rem_d = mask_in;
                        end else begin
                            state_d = STATE_IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = STATE_IDLE;
                rem_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= STATE_IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    assign bit_valid  = run;
    assign bit_onehot = run ? lsb : '0;
    assign bit_last   = last;

`ifdef RIGHTMOST_BIT_SEQUENCER_INDEX_EN
    localparam int unsigned INDEX_WIDTH = index_width(WORD_WIDTH);

    logic [WORD_WIDTH-1:0]  next_onehot;
    logic [INDEX_WIDTH-1:0] index_q, index_d;

    // Encode the next remaining mask so the index register lines up with rem_q.
    assign next_onehot = rem_d & (~rem_d + ONE_W);

    onehot_to_binary #(
        .WORD_WIDTH  (WORD_WIDTH),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_onehot_to_binary (
        .onehot_i (next_onehot),
        .index_o  (index_d)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            index_q <= '0;
        end else begin
            index_q <= index_d;
        end
    end

    assign bit_index = run ? index_q : '0;
`endif

endmodule

// File: tb/tb_rightmost_bit_sequencer.sv
// Scoreboard bench for rightmost_bit_sequencer: expected beats are queued at mask
// acceptance and compared as the DUT hands them out.
module tb_rightmost_bit_sequencer;
    import rightmost_bit_sequencer_pkg::*;

    localparam int unsigned WW = 8;
    localparam int unsigned IW = index_width(WW);

    logic          clock      = 1'b0;
    logic          reset_n    = 1'b0;
    logic          mask_valid = 1'b0;
    logic          bit_ready  = 1'b0;
    logic [WW-1:0] mask_in    = '0;
    logic          mask_ready;
    logic          bit_valid;
    logic          bit_last;
    logic [WW-1:0] bit_onehot;
`ifdef RIGHTMOST_BIT_SEQUENCER_INDEX_EN
    logic [IW-1:0] bit_index;
`endif

    typedef struct packed {
        logic [WW-1:0] onehot;
        logic          last;
        logic [IW-1:0] index;
    } beat_t;

    beat_t       sb[$];
    int unsigned n_checks   = 0;
    int unsigned n_pass     = 0;
    int unsigned beat_count = 0;

    rightmost_bit_sequencer #(.WORD_WIDTH(WW)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .mask_valid (mask_valid),
        .mask_ready (mask_ready),
        .mask_in    (mask_in),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .bit_onehot (bit_onehot),
`ifdef RIGHTMOST_BIT_SEQUENCER_INDEX_EN
        .bit_index  (bit_index),
`endif
        .bit_last   (bit_last)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: scan bits LSB first; the highest set bit carries last.
    task automatic push_mask(input logic [WW-1:0] m);
        beat_t       b;
        int unsigned hi;
        hi = 0;
        for (int unsigned i = 0; i < WW; i++) if (m[i]) hi = i;
        for (int unsigned i = 0; i < WW; i++) begin
            if (m[i]) begin
                b        = '0;
                b.onehot = '0;
                b.onehot[i] = 1'b1;
                b.last   = (i == hi);
                b.index  = IW'(i);
                sb.push_back(b);
            end
        end
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            if (bit_valid && bit_ready) begin
                beat_count++;
                if (sb.size() == 0) begin
                    check_eq("beat_unexpected", 32'(bit_onehot), 32'd0);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    check_eq("beat_onehot", 32'(bit_onehot), 32'(e.onehot));
                    check_eq("beat_last", 32'(bit_last), 32'(e.last));
`ifdef RIGHTMOST_BIT_SEQUENCER_INDEX_EN
                    check_eq("beat_index", 32'(bit_index), 32'(e.index));
`endif
                end
            end
            if (mask_valid && mask_ready && (mask_in != '0)) push_mask(mask_in);
        end
    end

    // Called just after a rising edge; returns just after the edge that accepts the mask.
    task automatic send_mask(input logic [WW-1:0] m);
        int unsigned budget;
        budget     = 0;
        mask_in    = m;
        mask_valid = 1'b1;
        @(negedge clock);
        while (!mask_ready && budget < 100) begin
            @(negedge clock);
            budget++;
        end
        if (budget >= 100) check_eq("mask_accept_timeout", 32'(mask_ready), 32'd1);
        @(posedge clock);
        #1;
        mask_valid = 1'b0;
        mask_in    = '0;
    endtask

    task automatic wait_drain();
        int unsigned budget;
        budget = 0;
        while ((sb.size() != 0 || bit_valid) && budget < 100) begin
            @(posedge clock);
            #1;
            budget++;
        end
        check_eq("drain_sb_empty", 32'(sb.size()), 32'd0);
        check_eq("drain_idle", 32'(bit_valid), 32'd0);
    endtask

    int unsigned b0;

    initial begin
        #2;
        check_eq("rst_valid", 32'(bit_valid), 32'd0);
        check_eq("rst_onehot", 32'(bit_onehot), 32'd0);
        check_eq("rst_last", 32'(bit_last), 32'd0);
        check_eq("rst_mask_ready", 32'(mask_ready), 32'd1);
`ifdef RIGHTMOST_BIT_SEQUENCER_INDEX_EN
        check_eq("rst_index", 32'(bit_index), 32'd0);
`endif
        @(posedge clock);
        #1;
        reset_n   = 1'b1;
        bit_ready = 1'b1;
        @(posedge clock);
        #1;

        // Basic: first beat appears the cycle after acceptance
        send_mask(8'b0101_1000);
        check_eq("basic_latency", 32'(bit_valid), 32'd1);
        check_eq("basic_first", 32'(bit_onehot), 32'h08);
        wait_drain();

        // Zero mask is accepted and dropped
        mask_in    = '0;
        mask_valid = 1'b1;
        @(negedge clock);
        check_eq("zero_ready", 32'(mask_ready), 32'd1);
        @(posedge clock);
        #1;
        mask_valid = 1'b0;
        @(negedge clock);
        check_eq("zero_no_valid", 32'(bit_valid), 32'd0);
        check_eq("zero_ready_next", 32'(mask_ready), 32'd1);
        @(posedge clock);
        #1;

        // Back-to-back: next mask loads on the last beat of the previous one
        send_mask(8'h81);
        @(negedge clock);
        check_eq("b2b_beat0", 32'(bit_onehot), 32'h01);
        @(posedge clock);
        #1;
        mask_in    = 8'h02;
        mask_valid = 1'b1;
        @(negedge clock);
        check_eq("b2b_beat1", 32'(bit_onehot), 32'h80);
        check_eq("b2b_beat1_last", 32'(bit_last), 32'd1);
        check_eq("b2b_overlap_ready", 32'(mask_ready), 32'd1);
        @(posedge clock);
        #1;
        mask_valid = 1'b0;
        mask_in    = '0;
        @(negedge clock);
        check_eq("b2b_no_bubble", 32'(bit_valid), 32'd1);
        check_eq("b2b_beat2", 32'(bit_onehot), 32'h02);
        check_eq("b2b_beat2_last", 32'(bit_last), 32'd1);
        wait_drain();

        // Stall: outputs hold while bit_ready is low
        bit_ready = 1'b0;
        send_mask(8'h06);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check_eq("stall_valid", 32'(bit_valid), 32'd1);
            check_eq("stall_onehot", 32'(bit_onehot), 32'h02);
            check_eq("stall_last", 32'(bit_last), 32'd0);
            check_eq("stall_mask_ready", 32'(mask_ready), 32'd0);
        end
        @(posedge clock);
        #1;
        bit_ready = 1'b1;
        wait_drain();

        // Boundaries: all ones and MSB only
        b0 = beat_count;
        send_mask(8'hFF);
        wait_drain();
        check_eq("ff_beats", 32'(beat_count - b0), 32'd8);
        b0 = beat_count;
        send_mask(8'h80);
        @(negedge clock);
        check_eq("msb_last", 32'(bit_last), 32'd1);
        wait_drain();
        check_eq("msb_beats", 32'(beat_count - b0), 32'd1);

        // Reset mid-run after the first beat
        send_mask(8'hF0);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("mrst_valid", 32'(bit_valid), 32'd0);
        check_eq("mrst_onehot", 32'(bit_onehot), 32'd0);
        check_eq("mrst_ready", 32'(mask_ready), 32'd1);
        sb.delete();
        b0 = beat_count;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check_eq("mrst_idle_valid", 32'(bit_valid), 32'd0);
            check_eq("mrst_idle_ready", 32'(mask_ready), 32'd1);
        end
        check_eq("mrst_no_stale", 32'(beat_count - b0), 32'd0);
        @(posedge clock);
        #1;

        send_mask(8'h05);
        wait_drain();
        check_eq("final_beats", 32'(beat_count - b0), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
